algo_sram_1r1w_bnk: RTL and testbench

Behavioural responder for the physical 1R1W SRAM ports (t*_writeA/addrA/dinA, t*_readB/addrB/doutB) that the multiport algorithm cores drive. It models NUMBNK independent banks of NUMVROW x WIDTH with a fixed SRAM_DELAY read pipeline, and a post-reset zero-fill sweep. It sits under the algo top in simulation and formal benches in place of the vendor macros, so every algo block is checked against one deterministic memory model.

---
 rtl/algo_sram_1r1w_bnk.sv | 137 +++++++++++++
 tb/tb_algo_sram_1r1w_bnk.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/algo_sram_1r1w_bnk.sv
// Behavioural multi-bank 1R1W SRAM model with a fixed-latency read pipeline and a post-reset zero-fill sweep.
// Reads sample the array before same-edge writes, so a colliding read returns the old row contents.
module algo_sram_1r1w_bnk #(
  parameter int NUMBNK     = 8,
  parameter int WIDTH      = 32,
  parameter int NUMVROW    = 1024,
  parameter int BITVROW    = 10,
  parameter int SRAM_DELAY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ready,
  input  logic [NUMBNK-1:0]         writeA,
  input  logic [NUMBNK*BITVROW-1:0] addrA,
  input  logic [NUMBNK*WIDTH-1:0]   dinA,
  input  logic [NUMBNK-1:0]         readB,
  input  logic [NUMBNK*BITVROW-1:0] addrB,
  output logic [NUMBNK*WIDTH-1:0]   doutB,
  output logic [NUMBNK-1:0]         doutB_vld
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [BITVROW-1:0] LAST_ROW = BITVROW'(NUMVROW - 1);

  state_t             state;
  state_t             state_nxt;
  logic [BITVROW-1:0] init_row;
  logic               init_last;

  function automatic logic in_range(input logic [BITVROW-1:0] row);
    return int'(row) < NUMVROW;
  endfunction

  assign init_last = (state == INIT) && (init_row == LAST_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (init_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_row <= '0;
    end else if (state == INIT) begin
      init_row <= init_row + BITVROW'(1);
    end
  end

  for (genvar b = 0; b < NUMBNK; b++) begin : g_bank
    logic [WIDTH-1:0]      mem [NUMVROW];
    logic                  wr_en;
    logic [BITVROW-1:0]    wr_row;
    logic [WIDTH-1:0]      wr_data;
    logic [BITVROW-1:0]    rd_row;
    logic                  rd_en;
    logic [WIDTH-1:0]      data_p [SRAM_DELAY];
    logic [SRAM_DELAY-1:0] vld_p;
    logic [WIDTH-1:0]      dout_q;
    logic                  dout_vld_q;

    assign rd_row = addrB[b*BITVROW +: BITVROW];
    assign rd_en  = readB[b] && (state == RUN);

    // The sweep owns the write port while INIT; user writes are dropped then.
    always_comb begin
      wr_en   = 1'b0;
      wr_row  = addrA[b*BITVROW +: BITVROW];
      wr_data = dinA[b*WIDTH +: WIDTH];
      if (state == INIT) begin
        wr_en   = 1'b1;
        wr_row  = init_row;
        wr_data = '0;
      end else if (writeA[b] && in_range(wr_row)) begin
        wr_en = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_row] <= wr_data;
      end
    end

    // Stage p0: array sampled on the request edge, ahead of any same-edge write.
    always_ff @(posedge clk) begin
      data_p[0] <= in_range(rd_row) ? mem[rd_row] : '0;
      for (int k = 1; k < SRAM_DELAY; k++) begin
        data_p[k] <= data_p[k-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= rd_en;
        for (int k = 1; k < SRAM_DELAY; k++) begin
          vld_p[k] <= vld_p[k-1];
        end
      end
    end

    // Output stage: data only advances with a valid result, otherwise it holds.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q     <= '0;
        dout_vld_q <= 1'b0;
      end else begin
        dout_vld_q <= vld_p[SRAM_DELAY-1];
        if (vld_p[SRAM_DELAY-1]) begin
          dout_q <= data_p[SRAM_DELAY-1];
        end
      end
    end

    assign doutB[b*WIDTH +: WIDTH] = dout_q;
    assign doutB_vld[b]            = dout_vld_q;
  end

endmodule

// File: tb/tb_algo_sram_1r1w_bnk.sv
// Randomised and directed bench for algo_sram_1r1w_bnk against a queue-based memory/latency reference model.
module tb_algo_sram_1r1w_bnk;
  localparam int NUMBNK     = 2;
  localparam int WIDTH      = 8;
  localparam int NUMVROW    = 16;
  localparam int BITVROW    = 4;
  localparam int SRAM_DELAY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic [1:0]  writeA = '0;
  logic [7:0]  addrA  = '0;
  logic [15:0] dinA   = '0;
  logic [1:0]  readB  = '0;
  logic [7:0]  addrB  = '0;
  logic [15:0] doutB;
  logic [1:0]  doutB_vld;

  algo_sram_1r1w_bnk #(
    .NUMBNK(NUMBNK), .WIDTH(WIDTH), .NUMVROW(NUMVROW), .BITVROW(BITVROW), .SRAM_DELAY(SRAM_DELAY)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .writeA(writeA), .addrA(addrA), .dinA(dinA),
    .readB(readB), .addrB(addrB), .doutB(doutB), .doutB_vld(doutB_vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         bank;
    int         due;
    logic [7:0] data;
  } rd_t;

  rd_t         pend[$];
  logic [7:0]  ref_mem [2][16];
  int          cyc = 0;
  int          edges = 0;
  logic        exp_ready = 1'b0;
  logic [1:0]  exp_vld = '0;
  logic [15:0] exp_dout = '0;

  // Drive one cycle of stimulus, advance the reference model across the edge, settle.
  task automatic step(input logic [1:0] wa, input logic [7:0] aa, input logic [15:0] da,
                      input logic [1:0] rb, input logic [7:0] ab);
    bit  was_rdy;
    int  ra;
    int  wr;
    rd_t e;
    writeA = wa; addrA = aa; dinA = da; readB = rb; addrB = ab;
    @(posedge clk);
    cyc++;
    if (rst) begin
      edges = 0;
      pend.delete();
      exp_vld  = '0;
      exp_dout = '0;
    end else begin
      was_rdy = (edges >= NUMVROW);
      edges++;
      exp_vld = '0;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        exp_vld[pend[0].bank]             = 1'b1;
        exp_dout[pend[0].bank*8 +: 8]     = pend[0].data;
        pend.delete(0);
      end
      if (was_rdy) begin
        for (int b = 0; b < 2; b++) begin
          ra = int'(ab[b*4 +: 4]);
          wr = int'(aa[b*4 +: 4]);
          if (rb[b]) begin
            e.bank = b;
            e.due  = cyc + SRAM_DELAY;
            e.data = (ra < NUMVROW) ? ref_mem[b][ra] : 8'h00;
            pend.push_back(e);
          end
          if (wa[b] && wr < NUMVROW) ref_mem[b][wr] = da[b*8 +: 8];
        end
      end
      if (edges == NUMVROW) begin
        for (int b = 0; b < 2; b++)
          for (int r = 0; r < NUMVROW; r++) ref_mem[b][r] = 8'h00;
      end
    end
    exp_ready = (edges >= NUMVROW);
    #1;
  endtask

  task automatic idle();
    step(2'b00, 8'h00, 16'h0000, 2'b00, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step(2'b11, 8'h00, 16'hFFFF, 2'b11, 8'h00);
    checks++;
    if ({ready, doutB_vld, doutB} !== 19'h0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b vld=%b dout=%h, required 0 00 0000", ready, doutB_vld, doutB);
    end
    rst = 1'b0;
    for (int i = 0; i < NUMVROW; i++) begin
      step(2'($urandom), 8'($urandom), 16'($urandom), 2'($urandom), 8'($urandom));
      checks++;
      if (ready !== (i == NUMVROW-1) || doutB_vld !== 2'b00) begin
        errors++;
        $display("FAIL init_sweep: edge %0d got ready=%b vld=%b, required ready=%b vld=00",
                 i+1, ready, doutB_vld, (i == NUMVROW-1));
      end
    end
    for (int i = 0; i < NUMVROW + SRAM_DELAY; i++) begin
      if (i < NUMVROW) step(2'b00, 8'h00, 16'h0000, 2'b11, {4'(i), 4'(i)});
      else idle();
      checks++;
      if ({ready, doutB_vld, doutB} !== {exp_ready, exp_vld, exp_dout} || doutB !== 16'h0000) begin
        errors++;
        $display("FAIL init_zero_read: cycle %0d got ready=%b vld=%b dout=%h, required ready=%b vld=%b dout=0000",
                 i, ready, doutB_vld, doutB, exp_ready, exp_vld);
      end
    end
  endtask

  task automatic test_write_read();
    logic [1:0] req_vld;
    step(2'b01, 8'h05, 16'h00A5, 2'b00, 8'h00);
    step(2'b00, 8'h00, 16'h0000, 2'b01, 8'h05);
    for (int i = 0; i < 3; i++) begin
      idle();
      req_vld = (i == 1) ? 2'b01 : 2'b00;
      checks++;
      if (doutB_vld !== req_vld || (i >= 1 && doutB[7:0] !== 8'hA5) || doutB_vld !== exp_vld) begin
        errors++;
        $display("FAIL write_read: cycle %0d got vld=%b dout0=%h, required vld=%b dout0=a5", i, doutB_vld, doutB[7:0], req_vld);
      end
    end
  endtask

  task automatic test_bank_indep();
    step(2'b11, 8'h33, 16'h2211, 2'b00, 8'h00);
    step(2'b00, 8'h00, 16'h0000, 2'b11, 8'h33);
    idle(); idle();
    checks++;
    if (doutB_vld !== 2'b11 || doutB !== 16'h2211) begin
      errors++;
      $display("FAIL bank_indep_both: got vld=%b dout=%h, required vld=11 dout=2211", doutB_vld, doutB);
    end
    step(2'b01, 8'h03, 16'h0099, 2'b10, 8'h30);
    idle(); idle();
    checks++;
    if (doutB_vld !== 2'b10 || doutB !== 16'h2211) begin
      errors++;
      $display("FAIL bank_indep_single: got vld=%b dout=%h, required vld=10 dout=2211", doutB_vld, doutB);
    end
    idle();
  endtask

  task automatic test_collision();
    step(2'b01, 8'h07, 16'h0033, 2'b00, 8'h00);
    step(2'b01, 8'h07, 16'h0044, 2'b01, 8'h07);
    step(2'b00, 8'h00, 16'h0000, 2'b01, 8'h07);
    idle();
    checks++;
    if (doutB_vld[0] !== 1'b1 || doutB[7:0] !== 8'h33) begin
      errors++;
      $display("FAIL collision_old: got vld0=%b dout0=%h, required 1 33", doutB_vld[0], doutB[7:0]);
    end
    idle();
    checks++;
    if (doutB_vld[0] !== 1'b1 || doutB[7:0] !== 8'h44) begin
      errors++;
      $display("FAIL collision_new: got vld0=%b dout0=%h, required 1 44", doutB_vld[0], doutB[7:0]);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  wv0 [16];
    logic [7:0]  wv1 [16];
    logic [1:0]  req_vld;
    logic [15:0] req_dout;
    int          pulses = 0;
    for (int i = 0; i < NUMVROW; i++) begin
      wv0[i] = 8'($urandom);
      wv1[i] = 8'($urandom);
      step(2'b11, {4'(i), 4'(i)}, {wv1[i], wv0[i]}, 2'b00, 8'h00);
    end
    for (int i = 0; i < NUMVROW + SRAM_DELAY + 1; i++) begin
      if (i < NUMVROW) step(2'b00, 8'h00, 16'h0000, 2'b11, {4'(i), 4'(i)});
      else idle();
      req_vld  = (i >= SRAM_DELAY && i < NUMVROW + SRAM_DELAY) ? 2'b11 : 2'b00;
      req_dout = (req_vld == 2'b11) ? {wv1[i-SRAM_DELAY], wv0[i-SRAM_DELAY]} : exp_dout;
      if (doutB_vld == 2'b11) pulses++;
      checks++;
      if (doutB_vld !== req_vld || doutB !== req_dout || doutB !== exp_dout) begin
        errors++;
        $display("FAIL back_to_back: cycle %0d got vld=%b dout=%h, required vld=%b dout=%h", i, doutB_vld, doutB, req_vld, req_dout);
      end
    end
    checks++;
    if (pulses !== NUMVROW) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d pulses, required %0d", pulses, NUMVROW);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom), 8'($urandom), 16'($urandom), 2'($urandom), 8'($urandom));
      checks++;
      if ({ready, doutB_vld, doutB} !== {exp_ready, exp_vld, exp_dout}) begin
        errors++;
        $display("FAIL random: cycle %0d got ready=%b vld=%b dout=%h, required ready=%b vld=%b dout=%h",
                 i, ready, doutB_vld, doutB, exp_ready, exp_vld, exp_dout);
      end
    end
    idle(); idle(); idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NUMVROW; i++) step(2'b11, {4'(i), 4'(i)}, 16'hFFFF, 2'b00, 8'h00);
    step(2'b00, 8'h00, 16'h0000, 2'b11, 8'h00);
    step(2'b00, 8'h00, 16'h0000, 2'b11, 8'h11);
    rst = 1'b1;
    idle();
    checks++;
    if ({ready, doutB_vld, doutB} !== 19'h0) begin
      errors++;
      $display("FAIL mid_reset_values: got ready=%b vld=%b dout=%h, required 0 00 0000", ready, doutB_vld, doutB);
    end
    rst = 1'b0;
    for (int i = 0; i < NUMVROW; i++) begin
      step(2'b00, 8'h00, 16'h0000, 2'($urandom), 8'($urandom));
      checks++;
      if (ready !== (i == NUMVROW-1) || doutB_vld !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset_sweep: edge %0d got ready=%b vld=%b, required ready=%b vld=00",
                 i+1, ready, doutB_vld, (i == NUMVROW-1));
      end
    end
    for (int i = 0; i < NUMVROW + SRAM_DELAY; i++) begin
      if (i < NUMVROW) step(2'b00, 8'h00, 16'h0000, 2'b11, {4'(i), 4'(i)});
      else idle();
      checks++;
      if ({doutB_vld, doutB} !== {exp_vld, exp_dout} || doutB !== 16'h0000 ||
          doutB_vld !== ((i >= SRAM_DELAY) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL mid_reset_zero: cycle %0d got vld=%b dout=%h, required vld=%b dout=0000", i, doutB_vld, doutB, exp_vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bank_indep();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
